// File: rtl/pipe_ctrl.sv
// Pipeline control for an in-order NSTAGE-deep pipe: load-use stall, branch
// flush, operand forwarding selects, halt drain and retirement counting.
module pipe_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned REG_AW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [REG_AW-1:0]        in_dst,
  input  logic                     in_wr,
  input  logic                     in_load,
  input  logic                     in_halt,
  input  logic [REG_AW-1:0]        in_src1,
  input  logic [REG_AW-1:0]        in_src2,
  input  logic                     in_use1,
  input  logic                     in_use2,
  input  logic                     flush,
  output logic [NSTAGE-1:0]        stage_valid,
  output logic [NSTAGE*DATA_W-1:0] stage_data,
  output logic                     stall,
  output logic [1:0]               fwd1_sel,
  output logic [1:0]               fwd2_sel,
  output logic                     hlt,
  output logic [15:0]              retired
);

  localparam int unsigned Last = NSTAGE - 1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
    logic              halt;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              use1;
    logic              use2;
  } stage_t;

  stage_t        st_q [NSTAGE];
  stage_t        st_d [NSTAGE];
  stage_t        fetch;
  logic          halt_seen_q, halt_seen_d;
  logic          hlt_q;
  logic [15:0]   retired_q;

  // Select a forwarding source for one stage-1 operand; stage 2 is younger and wins.
  function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] src, input logic rd,
                                          input stage_t s1, input stage_t s2,
                                          input stage_t s3);
    logic [1:0] sel;
    sel = 2'b00;
    if (s1.valid && rd) begin
      if (s2.valid && s2.wr && (s2.dst != '0) && (s2.dst == src)) begin
        sel = 2'b01;
      end else if (s3.valid && s3.wr && (s3.dst != '0) && (s3.dst == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Load-use hazard detect, ready and forwarding selects.
  always_comb begin
    stall = st_q[0].valid & st_q[1].valid & st_q[1].load & st_q[1].wr &
            (st_q[1].dst != '0) &
            ((st_q[0].use1 & (st_q[0].src1 == st_q[1].dst)) |
             (st_q[0].use2 & (st_q[0].src2 == st_q[1].dst)));
    in_ready = ~stall & ~halt_seen_q;
    fwd1_sel = fwd_pick(st_q[1].src1, st_q[1].use1, st_q[1], st_q[2], st_q[3]);
    fwd2_sel = fwd_pick(st_q[1].src2, st_q[1].use2, st_q[1], st_q[2], st_q[3]);
  end

  // Next-state of the stage registers; a stall holds decode and injects a bubble behind it.
  always_comb begin
    fetch = '0;
    if (in_valid && in_ready && !flush) begin
      fetch.valid = 1'b1;
      fetch.data  = in_data;
      fetch.dst   = in_dst;
      fetch.wr    = in_wr;
      fetch.load  = in_load;
      fetch.halt  = in_halt;
      fetch.src1  = in_src1;
      fetch.src2  = in_src2;
      fetch.use1  = in_use1;
      fetch.use2  = in_use2;
    end
    for (int k = 1; k < NSTAGE; k++) begin
      st_d[k] = st_q[k-1];
    end
    if (stall) begin
      st_d[0] = st_q[0];
      st_d[1] = '0;
    end else begin
      st_d[0] = fetch;
    end
    halt_seen_d = halt_seen_q | (st_d[0].valid & st_d[0].halt);
  end

  // State registers; the HLT itself is counted on the edge it leaves the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        st_q[k] <= '0;
      end
      halt_seen_q <= 1'b0;
      hlt_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      st_q        <= st_d;
      halt_seen_q <= halt_seen_d;
      if (st_q[Last].valid && !hlt_q) begin
        retired_q <= retired_q + 16'd1;
      end
      if (st_q[Last].valid && st_q[Last].halt) begin
        hlt_q <= 1'b1;
      end
    end
  end

  // Flatten stage state onto the output buses.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stage_valid[k]                 = st_q[k].valid;
      stage_data[k*DATA_W +: DATA_W] = st_q[k].data;
    end
    hlt     = hlt_q | (st_q[Last].valid & st_q[Last].halt);
    retired = retired_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios followed by
// random traffic, all checked against an instruction-level reference model.
module tb_pipe_ctrl;

  localparam int DATA_W = 16;
  localparam int NSTAGE = 4;
  localparam int REG_AW = 4;
  localparam int L      = NSTAGE - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid, in_ready, in_wr, in_load, in_halt, in_use1, in_use2, flush;
  logic [DATA_W-1:0]        in_data;
  logic [REG_AW-1:0]        in_dst, in_src1, in_src2;
  logic [NSTAGE-1:0]        stage_valid;
  logic [NSTAGE*DATA_W-1:0] stage_data;
  logic                     stall, hlt;
  logic [1:0]               fwd1_sel, fwd2_sel;
  logic [15:0]              retired;

  always #5 clk = ~clk;

  pipe_ctrl #(.DATA_W(DATA_W), .NSTAGE(NSTAGE), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dst(in_dst), .in_wr(in_wr), .in_load(in_load), .in_halt(in_halt),
    .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
    .flush(flush), .stage_valid(stage_valid), .stage_data(stage_data), .stall(stall),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .hlt(hlt), .retired(retired)
  );

  typedef struct {
    bit              valid;
    bit [DATA_W-1:0] data;
    bit [REG_AW-1:0] dst;
    bit              wr, load, halt;
    bit [REG_AW-1:0] src1, src2;
    bit              use1, use2;
  } ins_t;

  // Reference model: which instruction sits in each stage, plus halt/retire bookkeeping.
  ins_t        m [NSTAGE];
  ins_t        nop;
  bit          m_hs, m_hlt;
  int unsigned m_ret;
  bit          cur_v, cur_fl;
  ins_t        cur_x;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic ins_t mk(input bit [DATA_W-1:0] d, input int dst, input bit wr,
                              input bit ld, input bit ht, input int s1, input int s2,
                              input bit u1, input bit u2);
    ins_t r;
    r.valid = 1'b1; r.data = d; r.dst = REG_AW'(dst); r.wr = wr; r.load = ld; r.halt = ht;
    r.src1 = REG_AW'(s1); r.src2 = REG_AW'(s2); r.use1 = u1; r.use2 = u2;
    return r;
  endfunction

  function automatic bit exp_stall();
    ins_t c, p;
    c = m[0];
    p = m[1];
    if (!(c.valid && p.valid && p.load && p.wr && p.dst != 0)) return 1'b0;
    return (c.use1 && c.src1 == p.dst) || (c.use2 && c.src2 == p.dst);
  endfunction

  // Forward from the nearest older in-flight writer of src (never register 0).
  function automatic bit [1:0] exp_fwd(input bit [REG_AW-1:0] src, input bit rd);
    if (!(m[1].valid && rd)) return 2'b00;
    for (int k = 2; k <= 3; k++) begin
      if (m[k].valid && m[k].wr && m[k].dst != 0 && m[k].dst == src) return 2'(k - 1);
    end
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit st;
    bit [NSTAGE-1:0] sv;
    st = exp_stall();
    for (int k = 0; k < NSTAGE; k++) sv[k] = m[k].valid;
    chk("stall", 64'(stall), 64'(st));
    chk("in_ready", 64'(in_ready), 64'(!st && !m_hs));
    chk("fwd1_sel", 64'(fwd1_sel), 64'(exp_fwd(m[1].src1, m[1].use1)));
    chk("fwd2_sel", 64'(fwd2_sel), 64'(exp_fwd(m[1].src2, m[1].use2)));
    chk("stage_valid", 64'(stage_valid), 64'(sv));
    for (int k = 0; k < NSTAGE; k++) begin
      if (m[k].valid)
        chk($sformatf("stage_data%0d", k), 64'(stage_data[k*DATA_W +: DATA_W]), 64'(m[k].data));
    end
    chk("hlt", 64'(hlt), 64'(m_hlt || (m[L].valid && m[L].halt)));
    chk("retired", 64'(retired), 64'(m_ret));
  endtask

  // Present inputs mid-cycle and check the model against the outputs.
  task automatic drive(input bit v, input ins_t x, input bit fl);
    @(negedge clk);
    cur_v = v; cur_x = x; cur_fl = fl;
    in_valid = v; in_data = x.data; in_dst = x.dst; in_wr = x.wr; in_load = x.load;
    in_halt = x.halt; in_src1 = x.src1; in_src2 = x.src2; in_use1 = x.use1;
    in_use2 = x.use2; flush = fl;
    #1;
    check_model();
  endtask

  // Take the rising edge and move the model forward by one cycle.
  task automatic adv();
    bit st, rdy;
    ins_t nw;
    @(posedge clk);
    st  = exp_stall();
    rdy = !st && !m_hs;
    if (m[L].valid && !m_hlt) m_ret = (m_ret + 1) % 65536;
    if (m[L].valid && m[L].halt) m_hlt = 1'b1;
    nw = nop;
    if (cur_v && rdy && !cur_fl) begin
      nw = cur_x;
      nw.valid = 1'b1;
    end
    for (int k = L; k >= 2; k--) m[k] = m[k-1];
    if (st) m[1] = nop;
    else begin
      m[1] = m[0];
      m[0] = nw;
    end
    if (m[0].valid && m[0].halt) m_hs = 1'b1;
  endtask

  task automatic step(input bit v, input ins_t x, input bit fl);
    drive(v, x, fl);
    adv();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, nop, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    for (int k = 0; k < NSTAGE; k++) m[k] = nop;
    m_hs = 1'b0; m_hlt = 1'b0; m_ret = 0;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fwd1", 64'(fwd1_sel), 64'd0);
    chk("rst_fwd2", 64'(fwd2_sel), 64'd0);
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_stage_data", 64'(stage_data), 64'd0);
    chk("rst_hlt", 64'(hlt), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    ins_t x;
    in_valid = 0; in_data = '0; in_dst = '0; in_wr = 0; in_load = 0; in_halt = 0;
    in_src1 = '0; in_src2 = '0; in_use1 = 0; in_use2 = 0; flush = 0;
    do_reset();

    // Back-to-back ALU ops forwarding R3 from stage 2 then stage 3.
    step(1'b1, mk(16'h1111, 3, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, mk(16'h2222, 0, 0, 0, 0, 3, 0, 1, 0), 1'b0);
    step(1'b1, mk(16'h3333, 0, 0, 0, 0, 0, 3, 0, 1), 1'b0);
    drive(1'b0, nop, 1'b0);
    chk("b2b_fwd1_s2", 64'(fwd1_sel), 64'd1);
    adv();
    drive(1'b0, nop, 1'b0);
    chk("b2b_fwd2_s3", 64'(fwd2_sel), 64'd2);
    adv();
    drain(NSTAGE);

    // Load R5 then use R5: one bubble, then forward from stage 3.
    step(1'b1, mk(16'h4444, 5, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, mk(16'h5555, 0, 0, 0, 0, 5, 0, 1, 0), 1'b0);
    drive(1'b1, mk(16'h6666, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("lu_stall", 64'(stall), 64'd1);
    chk("lu_ready", 64'(in_ready), 64'd0);
    adv();
    drive(1'b0, nop, 1'b0);
    chk("lu_stall_once", 64'(stall), 64'd0);
    chk("lu_bubble", 64'(stage_valid[1]), 64'd0);
    adv();
    drive(1'b0, nop, 1'b0);
    chk("lu_fwd1_s3", 64'(fwd1_sel), 64'd2);
    adv();
    drain(NSTAGE);

    // Load to R0 never stalls or forwards.
    step(1'b1, mk(16'h7777, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    drive(1'b1, mk(16'h8888, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0);
    adv();
    drive(1'b0, nop, 1'b0);
    chk("r0_stall", 64'(stall), 64'd0);
    adv();
    drive(1'b0, nop, 1'b0);
    chk("r0_fwd1", 64'(fwd1_sel), 64'd0);
    chk("r0_fwd2", 64'(fwd2_sel), 64'd0);
    adv();
    drain(NSTAGE);

    // Flush without stall kills the fetch; flush during stall is ignored.
    step(1'b1, mk(16'h9999, 2, 1, 0, 0, 0, 0, 0, 0), 1'b1);
    drive(1'b0, nop, 1'b0);
    chk("flush_kill", 64'(stage_valid[0]), 64'd0);
    adv();
    step(1'b1, mk(16'hAAAA, 6, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, mk(16'hBEEF, 0, 0, 0, 0, 0, 6, 0, 1), 1'b0);
    step(1'b0, nop, 1'b1);
    drive(1'b0, nop, 1'b0);
    chk("flush_ign_v", 64'(stage_valid[0]), 64'd1);
    chk("flush_ign_d", 64'(stage_data[DATA_W-1:0]), 64'hBEEF);
    adv();
    drain(NSTAGE);

    // Three ops then HLT: hlt after NSTAGE-1 cycles, retired settles at 4.
    do_reset();
    step(1'b1, mk(16'h0001, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, mk(16'h0002, 2, 1, 0, 0, 1, 0, 1, 0), 1'b0);
    step(1'b1, mk(16'h0003, 3, 1, 0, 0, 2, 1, 1, 1), 1'b0);
    step(1'b1, mk(16'h0004, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, mk(16'hDEAD, 7, 1, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("halt_ready", 64'(in_ready), 64'd0);
      chk("halt_hlt", 64'(hlt), 64'(i >= L));
      chk("halt_retired", 64'(retired), 64'(i < 4 ? i : 4));
      adv();
    end

    // Reset in the middle of a stall, then fill latency after release.
    do_reset();
    step(1'b1, mk(16'hC0DE, 4, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, mk(16'hC0DF, 0, 0, 0, 0, 4, 0, 1, 0), 1'b0);
    drive(1'b0, nop, 1'b0);
    chk("mid_stall", 64'(stall), 64'd1);
    do_reset();
    step(1'b1, mk(16'h1234, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < NSTAGE; i++) begin
      drive(1'b0, nop, 1'b0);
      chk("post_rst_lat", 64'(stage_valid), 64'(1 << i));
      adv();
    end

    // Random traffic with a narrow register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      x.valid = 1'b1;
      x.data  = DATA_W'($urandom);
      x.dst   = REG_AW'($urandom_range(0, 3));
      x.wr    = ($urandom_range(0, 3) != 0);
      x.load  = ($urandom_range(0, 2) == 0);
      x.halt  = ($urandom_range(0, 49) == 0);
      x.src1  = REG_AW'($urandom_range(0, 3));
      x.src2  = REG_AW'($urandom_range(0, 3));
      x.use1  = $urandom_range(0, 1);
      x.use2  = $urandom_range(0, 1);
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 6) == 0);
      if (m_hlt && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
